data_bus_arbiter: RTL and testbench

//  Shares the single-port data memory bus between N requesters: CPU load/store

---
 rtl/data_bus_arbiter_if.sv | 32 +++
 rtl/data_bus_arbiter.sv | 100 ++++++++++
 tb/tb_data_bus_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/data_bus_arbiter_if.sv
// Shared data-memory bus bundle: per-requester request/lock/payload lanes,
// one-hot grant back to requesters, and the muxed single-port memory side.
interface data_bus_arbiter_if #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 8
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    lock;
  logic [N_REQ-1:0]    wr;
  logic [N_REQ*AW-1:0] addr;
  logic [N_REQ*DW-1:0] wdata;
  logic [N_REQ-1:0]    gnt;
  logic [DW-1:0]       rdata;
  logic [AW-1:0]       mem_addr;
  logic                mem_wr;
  logic                mem_rd;
  logic [DW-1:0]       mem_dout;
  logic [DW-1:0]       mem_din;

  // Requesters plus the memory model sit on the master side.
  modport master (
    output req, lock, wr, addr, wdata, mem_din,
    input  gnt, rdata, mem_addr, mem_wr, mem_rd, mem_dout
  );

  // The arbiter owns the grant and the memory-facing mux.
  modport slave (
    input  req, lock, wr, addr, wdata, mem_din,
    output gnt, rdata, mem_addr, mem_wr, mem_rd, mem_dout
  );
endinterface

// File: rtl/data_bus_arbiter.sv
// Arbitrates the single-port data memory between N requesters with registered
// one-hot grants, round-robin or fixed priority, and capped locked bursts.
module data_bus_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned AW        = 8,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter bit          RR        = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  data_bus_arbiter_if.slave bus
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [N_REQ-1:0] gnt_q;
  logic [IW-1:0]    gidx;
  logic [IW-1:0]    ptr;
  logic [BW-1:0]    burst_cnt;

  logic [N_REQ-1:0] cand_c;
  logic [IW-1:0]    start_c;
  logic [IW-1:0]    win_idx_c;
  logic             win_found_c;
  logic             hold_c;

  // Current holder is excluded from the release-edge arbitration only.
  always_comb begin
    int unsigned sum;
    logic [IW-1:0] idx;
    sum         = 0;
    idx         = '0;
    cand_c      = (state == GRANT) ? (bus.req & ~gnt_q) : bus.req;
    start_c     = RR ? ptr : '0;
    win_found_c = 1'b0;
    win_idx_c   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      sum = 32'(start_c) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = IW'(sum);
      if (!win_found_c && cand_c[idx]) begin
        win_found_c = 1'b1;
        win_idx_c   = idx;
      end
    end
  end

  assign hold_c = (state == GRANT) && bus.req[gidx] && bus.lock[gidx] &&
                  (burst_cnt < BW'(MAX_BURST - 1));

  // Grant state machine; a held lock skips arbitration until the burst cap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      gnt_q     <= '0;
      gidx      <= '0;
      ptr       <= '0;
      burst_cnt <= '0;
    end else if (hold_c) begin
      burst_cnt <= burst_cnt + BW'(1);
    end else begin
      burst_cnt <= '0;
      if (win_found_c) begin
        state <= GRANT;
        gnt_q <= N_REQ'(1) << win_idx_c;
        gidx  <= win_idx_c;
        ptr   <= (win_idx_c == IW'(N_REQ - 1)) ? '0 : win_idx_c + IW'(1);
      end else begin
        state <= IDLE;
        gnt_q <= '0;
      end
    end
  end

  assign bus.gnt = gnt_q;

  // Memory-side mux follows the registered grant; strobes only on a real beat.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.rdata    = '0;
    if (state == GRANT) begin
      bus.mem_addr = bus.addr[gidx*AW +: AW];
      bus.mem_dout = bus.wdata[gidx*DW +: DW];
      bus.rdata    = bus.mem_din;
      if (bus.req[gidx]) begin
        bus.mem_wr = bus.wr[gidx];
        bus.mem_rd = ~bus.wr[gidx];
      end
    end
  end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter: round-robin instance with a memory
// model, plus a fixed-priority instance for the starvation ordering.
module tb_data_bus_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [7:0] mem [0:255];

  always #5 clk = ~clk;

  data_bus_arbiter_if #(.N_REQ(3), .AW(8), .DW(8)) bus_rr ();
  data_bus_arbiter_if #(.N_REQ(3), .AW(8), .DW(8)) bus_fp ();

  data_bus_arbiter #(.N_REQ(3), .AW(8), .DW(8), .MAX_BURST(4), .RR(1'b1)) u_rr (
    .clk (clk),
    .rst (rst),
    .bus (bus_rr)
  );

  data_bus_arbiter #(.N_REQ(3), .AW(8), .DW(8), .MAX_BURST(4), .RR(1'b0)) u_fp (
    .clk (clk),
    .rst (rst),
    .bus (bus_fp)
  );

  // Address 0x20 is a fixed read-only location holding 0x5A.
  assign bus_rr.mem_din = (bus_rr.mem_addr == 8'h20) ? 8'h5A : mem[bus_rr.mem_addr];
  assign bus_fp.mem_din = 8'h00;

  always @(posedge clk) begin
    if (bus_rr.mem_wr) mem[bus_rr.mem_addr] <= bus_rr.mem_dout;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] exp_rr [6];
    logic [2:0] exp_fp [6];
    logic [2:0] exp_bu [6];
    exp_rr = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    exp_fp = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
    exp_bu = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};

    rst          = 1'b0;
    bus_rr.req   = 3'b111;
    bus_rr.lock  = 3'b000;
    bus_rr.wr    = 3'b000;
    bus_rr.addr  = '0;
    bus_rr.wdata = '0;
    bus_fp.req   = 3'b000;
    bus_fp.lock  = 3'b000;
    bus_fp.wr    = 3'b000;
    bus_fp.addr  = '0;
    bus_fp.wdata = '0;

    // Reset held with all requests active
    repeat (2) begin
      step(); settle();
      chk("rst_gnt", 32'(bus_rr.gnt), 32'h0);
      chk("rst_mem_wr", 32'(bus_rr.mem_wr), 32'h0);
      chk("rst_mem_rd", 32'(bus_rr.mem_rd), 32'h0);
    end
    step(); rst = 1'b1; bus_rr.req = 3'b000; settle();
    chk("post_rst_gnt", 32'(bus_rr.gnt), 32'h0);

    // Single read from requester 1; req drops one cycle late
    step(); bus_rr.req = 3'b010; bus_rr.addr[8 +: 8] = 8'h20; settle();
    chk("rd_latency_gnt", 32'(bus_rr.gnt), 32'h0);
    step(); settle();
    chk("rd_gnt", 32'(bus_rr.gnt), 32'h2);
    chk("rd_mem_rd", 32'(bus_rr.mem_rd), 32'h1);
    chk("rd_mem_wr", 32'(bus_rr.mem_wr), 32'h0);
    chk("rd_mem_addr", 32'(bus_rr.mem_addr), 32'h20);
    chk("rd_rdata", 32'(bus_rr.rdata), 32'h5A);
    step(); bus_rr.req = 3'b000; settle();
    chk("rd_one_beat_gnt", 32'(bus_rr.gnt), 32'h0);
    chk("rd_one_beat_rd", 32'(bus_rr.mem_rd), 32'h0);

    // Locked two-beat stack push with requester 1 waiting
    step();
    bus_rr.req = 3'b011; bus_rr.lock = 3'b001; bus_rr.wr = 3'b001;
    bus_rr.addr[0 +: 8] = 8'hFE; bus_rr.wdata[0 +: 8] = 8'hA1;
    settle();
    step(); settle();
    chk("push1_gnt", 32'(bus_rr.gnt), 32'h1);
    chk("push1_mem_wr", 32'(bus_rr.mem_wr), 32'h1);
    chk("push1_mem_addr", 32'(bus_rr.mem_addr), 32'hFE);
    chk("push1_mem_dout", 32'(bus_rr.mem_dout), 32'hA1);
    step();
    bus_rr.addr[0 +: 8] = 8'hFD; bus_rr.wdata[0 +: 8] = 8'hB2; bus_rr.lock = 3'b000;
    settle();
    chk("push2_gnt", 32'(bus_rr.gnt), 32'h1);
    chk("push2_mem_addr", 32'(bus_rr.mem_addr), 32'hFD);
    chk("push2_mem_dout", 32'(bus_rr.mem_dout), 32'hB2);
    step(); bus_rr.req = 3'b010; bus_rr.wr = 3'b000; settle();
    chk("after_push_gnt", 32'(bus_rr.gnt), 32'h2);
    chk("after_push_rd", 32'(bus_rr.mem_rd), 32'h1);
    chk("after_push_rdata", 32'(bus_rr.rdata), 32'h5A);
    chk("push_mem_fe", 32'(mem[8'hFE]), 32'hA1);
    chk("push_mem_fd", 32'(mem[8'hFD]), 32'hB2);
    step(); bus_rr.req = 3'b000; settle();
    chk("after_push_idle", 32'(bus_rr.gnt), 32'h0);

    // Round-robin vs fixed priority with all requests held, after a reset
    step(); rst = 1'b0; settle();
    step();
    rst = 1'b1; bus_rr.req = 3'b111; bus_rr.lock = 3'b000; bus_rr.wr = 3'b000;
    bus_fp.req = 3'b111;
    settle();
    chk("rr_pre_gnt", 32'(bus_rr.gnt), 32'h0);
    chk("fp_pre_gnt", 32'(bus_fp.gnt), 32'h0);
    for (int k = 0; k < 6; k++) begin
      step(); settle();
      chk($sformatf("rr_order%0d", k), 32'(bus_rr.gnt), 32'(exp_rr[k]));
      chk($sformatf("rr_no_gap%0d", k), 32'(bus_rr.mem_rd), 32'h1);
      chk($sformatf("fp_order%0d", k), 32'(bus_fp.gnt), 32'(exp_fp[k]));
    end
    step(); bus_rr.req = 3'b000; bus_fp.req = 3'b000; settle();
    chk("rr_order6", 32'(bus_rr.gnt), 32'h1);
    chk("fp_order6", 32'(bus_fp.gnt), 32'h1);
    step(); settle();
    chk("rr_idle", 32'(bus_rr.gnt), 32'h0);
    chk("fp_idle", 32'(bus_fp.gnt), 32'h0);

    // Burst cap: requester 2 locked, requester 0 waiting
    step();
    bus_rr.req = 3'b100; bus_rr.lock = 3'b100; bus_rr.wr = 3'b100;
    bus_rr.addr[16 +: 8] = 8'h30; bus_rr.wdata[16 +: 8] = 8'hC3;
    bus_rr.addr[0 +: 8] = 8'h40;
    settle();
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) bus_rr.req = 3'b101;
      settle();
      chk($sformatf("burst_gnt%0d", k), 32'(bus_rr.gnt), 32'(exp_bu[k]));
      chk($sformatf("burst_wr%0d", k), 32'(bus_rr.mem_wr), (k == 4) ? 32'h0 : 32'h1);
    end
    step(); bus_rr.req = 3'b000; bus_rr.lock = 3'b000; bus_rr.wr = 3'b000; settle();
    chk("burst_tail_gnt", 32'(bus_rr.gnt), 32'h4);
    chk("burst_tail_no_wr", 32'(bus_rr.mem_wr), 32'h0);
    step(); settle();
    chk("burst_idle", 32'(bus_rr.gnt), 32'h0);

    // Reset during second locked beat
    step();
    bus_rr.req = 3'b001; bus_rr.lock = 3'b001; bus_rr.wr = 3'b001;
    bus_rr.addr[0 +: 8] = 8'h50; bus_rr.wdata[0 +: 8] = 8'hD4;
    settle();
    step(); settle();
    chk("mid_beat1_gnt", 32'(bus_rr.gnt), 32'h1);
    step(); rst = 1'b0; settle();
    chk("mid_beat2_gnt", 32'(bus_rr.gnt), 32'h1);
    chk("mid_beat2_wr", 32'(bus_rr.mem_wr), 32'h1);
    step();
    rst = 1'b1; bus_rr.req = 3'b101; bus_rr.lock = 3'b000; bus_rr.wr = 3'b000;
    settle();
    chk("mid_rst_gnt", 32'(bus_rr.gnt), 32'h0);
    chk("mid_rst_wr", 32'(bus_rr.mem_wr), 32'h0);
    chk("mid_rst_rd", 32'(bus_rr.mem_rd), 32'h0);
    step(); settle();
    chk("mid_rst_ptr0_gnt", 32'(bus_rr.gnt), 32'h1);
    step(); bus_rr.req = 3'b000; settle();
    step(); settle();
    chk("final_idle", 32'(bus_rr.gnt), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
